// File: rtl/ldpc_iter_ctrl.sv
// Iteration controller for the QC-LDPC decoder.
// Launches node-update iterations, steps the syndrome judge after each one, stops on a
// parity pass, the iteration limit or a judge timeout, then presents the frame status on a
// valid/ready handshake and keeps saturating pass/fail statistics.
module ldpc_iter_ctrl #(
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned ITER_W   = 5,
  parameter int unsigned JUDGE_TO = 8,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic              iter_start,
  input  logic              iter_done,
  output logic              judge,
  input  logic              finish,
  input  logic              flag_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_success,
  output logic [ITER_W-1:0] out_iters,
  output logic              out_timeout,
  output logic              protocol_err,
  output logic [STAT_W-1:0] frames_ok,
  output logic [STAT_W-1:0] frames_fail
);

  localparam int unsigned TmoW = (JUDGE_TO > 1) ? $clog2(JUDGE_TO) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIter,
    StJudge,
    StResult,
    StDone
  } state_e;

  state_e            state;
  logic [ITER_W-1:0] iter_cnt;
  logic [TmoW-1:0]   tmo_cnt;

  // Controller FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      frame_ready  <= 1'b1;
      iter_start   <= 1'b0;
      judge        <= 1'b0;
      out_valid    <= 1'b0;
      out_success  <= 1'b0;
      out_iters    <= '0;
      out_timeout  <= 1'b0;
      protocol_err <= 1'b0;
      frames_ok    <= '0;
      frames_fail  <= '0;
      iter_cnt     <= '0;
      tmo_cnt      <= '0;
    end else begin
      iter_start <= 1'b0;
      case (state)
        StIdle: begin
          if (frame_valid) begin
            state        <= StIter;
            frame_ready  <= 1'b0;
            iter_start   <= 1'b1;
            iter_cnt     <= ITER_W'(1);
            protocol_err <= 1'b0;
          end
        end
        StIter: begin
          // iter_start high marks the launch cycle; a done in that cycle is ignored
          if (iter_done && !iter_start) begin
            state   <= StJudge;
            judge   <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        StJudge: begin
          if (finish) begin
            state <= StResult;
            judge <= 1'b0;
          end else if (tmo_cnt == TmoW'(JUDGE_TO - 1)) begin
            state       <= StDone;
            judge       <= 1'b0;
            out_valid   <= 1'b1;
            out_success <= 1'b0;
            out_timeout <= 1'b1;
            out_iters   <= iter_cnt;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
        end
        StResult: begin
          // flag_out is valid in this cycle, one after finish
          if (flag_out || (iter_cnt == ITER_W'(MAX_ITER))) begin
            state       <= StDone;
            out_valid   <= 1'b1;
            out_success <= flag_out;
            out_timeout <= 1'b0;
            out_iters   <= iter_cnt;
          end else begin
            state      <= StIter;
            iter_start <= 1'b1;
            iter_cnt   <= iter_cnt + ITER_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state       <= StIdle;
            out_valid   <= 1'b0;
            frame_ready <= 1'b1;
            if (out_success) begin
              if (frames_ok != {STAT_W{1'b1}}) frames_ok <= frames_ok + STAT_W'(1);
            end else begin
              if (frames_fail != {STAT_W{1'b1}}) frames_fail <= frames_fail + STAT_W'(1);
            end
          end
        end
        default: begin
          state       <= StIdle;
          frame_ready <= 1'b1;
          judge       <= 1'b0;
          out_valid   <= 1'b0;
        end
      endcase
      // Stray iter_done is flagged without disturbing the state; it also beats the clear on accept
      if (iter_done && (state != StIter)) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Scoreboard bench for ldpc_iter_ctrl: a driver emulates the node-update units and the
// syndrome judge from a per-frame plan, a reference model predicts each frame result, and a
// separate monitor checks every presented result and the statistics counters.
module tb_ldpc_iter_ctrl;

  localparam int unsigned MAX_ITER = 16;
  localparam int unsigned ITER_W   = 5;
  localparam int unsigned JUDGE_TO = 8;
  localparam int unsigned STAT_W   = 16;
  localparam int unsigned SAT_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_valid = 1'b0, iter_done = 1'b0, finish = 1'b0, flag_out = 1'b0;
  logic out_ready = 1'b0;

  logic              frame_ready, iter_start, judge, out_valid, out_success, out_timeout;
  logic              protocol_err;
  logic [ITER_W-1:0] out_iters;
  logic [STAT_W-1:0] frames_ok, frames_fail;

  logic              s_frame_ready, s_iter_start, s_judge, s_out_valid, s_out_success;
  logic              s_out_timeout, s_protocol_err;
  logic [ITER_W-1:0] s_out_iters;
  logic [SAT_W-1:0]  s_frames_ok, s_frames_fail;

  always #5 clk = ~clk;

  ldpc_iter_ctrl #(
    .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .JUDGE_TO(JUDGE_TO), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .iter_start(iter_start), .iter_done(iter_done), .judge(judge), .finish(finish),
    .flag_out(flag_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_success(out_success), .out_iters(out_iters), .out_timeout(out_timeout),
    .protocol_err(protocol_err), .frames_ok(frames_ok), .frames_fail(frames_fail)
  );

  // Narrow statistics copy so counter saturation is reachable in a short run
  ldpc_iter_ctrl #(
    .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .JUDGE_TO(JUDGE_TO), .STAT_W(SAT_W)
  ) dut_s (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(s_frame_ready),
    .iter_start(s_iter_start), .iter_done(iter_done), .judge(s_judge), .finish(finish),
    .flag_out(flag_out), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_success(s_out_success), .out_iters(s_out_iters), .out_timeout(s_out_timeout),
    .protocol_err(s_protocol_err), .frames_ok(s_frames_ok), .frames_fail(s_frames_fail)
  );

  typedef struct {
    bit success;
    int iters;
    bit timeout;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_ok = 0;
  int   exp_fail = 0;
  bit   flags[MAX_ITER+2];
  int   tmo_at = 0;
  bit   hold_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of a frame from its plan: judge verdict per iteration, or a silent judge
  function automatic res_t model();
    res_t r;
    r.success = 1'b0;
    r.iters   = MAX_ITER;
    r.timeout = 1'b0;
    for (int k = 1; k <= MAX_ITER; k++) begin
      if (k == tmo_at) begin
        r.iters = k;
        r.timeout = 1'b1;
        return r;
      end
      if (flags[k]) begin
        r.iters = k;
        r.success = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int sat(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic wait_frame_ready();
    int n = 0;
    while (frame_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("frame_ready_wait", frame_ready, 1);
  endtask

  task automatic run_frame(input bit do_bp);
    int n;
    int cnt;
    wait_frame_ready();
    exp_q.push_back(model());
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("prot_err_clear_on_accept", protocol_err, 0);
    for (int k = 1; k <= MAX_ITER + 1; k++) begin
      n = 0;
      while (iter_start !== 1'b1 && out_valid !== 1'b1 && n < 400) begin
        tick();
        n++;
      end
      if (out_valid === 1'b1) break;
      chk("iter_start_wait", iter_start, 1);
      if (iter_start !== 1'b1) break;
      repeat ($urandom_range(1, 4)) tick();
      iter_done = 1'b1;
      tick();
      iter_done = 1'b0;
      if (k == tmo_at) begin
        cnt = 0;
        while (judge === 1'b1 && cnt < 50) begin
          tick();
          cnt++;
        end
        chk("judge_high_cycles", cnt, JUDGE_TO);
      end else begin
        repeat ($urandom_range(0, JUDGE_TO - 1)) tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        flag_out = flags[k];
        tick();
        flag_out = 1'b0;
      end
    end
    if (do_bp) begin
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid === 1'b1) cnt++;
        frame_valid = (i == 2 || i == 3);
        iter_done = (i == 5);
        tick();
      end
      frame_valid = 1'b0;
      iter_done = 1'b0;
      chk("bp_valid_held", cnt, 10);
      chk("stray_done_in_done", protocol_err, 1);
      hold_ready = 1'b0;
    end
    wait_frame_ready();
    if (do_bp) begin
      tick();
      chk("bp_frame_not_queued_ready", frame_ready, 1);
      chk("bp_frame_not_queued_start", iter_start, 0);
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < MAX_ITER + 2; k++) flags[k] = 1'b0;
    tmo_at = 0;
  endtask

  // Consumer readiness, randomly throttled unless the driver forces backpressure
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares presented results against the scoreboard queue
  initial begin
    int   pulses = 0;
    bit   prev_v = 1'b0;
    bit   prev_r = 1'b0;
    bit   stat_pending = 1'b0;
    res_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pulses = 0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        stat_pending = 1'b0;
      end else begin
        if (stat_pending) begin
          chk("frames_ok", frames_ok, exp_ok);
          chk("frames_fail", frames_fail, exp_fail);
          chk("frames_ok_sat", s_frames_ok, sat(exp_ok));
          chk("frames_fail_sat", s_frames_fail, sat(exp_fail));
          stat_pending = 1'b0;
        end
        if (iter_start === 1'b1) pulses++;
        if (prev_v && !prev_r) chk("out_valid_held", out_valid, 1);
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", out_valid, 0);
          end else begin
            e = exp_q[0];
            chk("out_success", out_success, e.success);
            chk("out_iters", out_iters, e.iters);
            chk("out_timeout", out_timeout, e.timeout);
            if (out_ready === 1'b1) begin
              chk("iter_start_pulses", pulses, e.iters);
              if (e.success) exp_ok++;
              else exp_fail++;
              void'(exp_q.pop_front());
              pulses = 0;
              stat_pending = 1'b1;
            end
          end
        end
        prev_v = (out_valid === 1'b1);
        prev_r = (out_ready === 1'b1);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  // Driver
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_frame_ready", frame_ready, 1);
    chk("rst_iter_start", iter_start, 0);
    chk("rst_judge", judge, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_success", out_success, 0);
    chk("rst_out_iters", out_iters, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_protocol_err", protocol_err, 0);
    chk("rst_frames_ok", frames_ok, 0);
    chk("rst_frames_fail", frames_fail, 0);

    // Stray iter_done in idle, then reset while the judge is running
    iter_done = 1'b1;
    tick();
    iter_done = 1'b0;
    chk("stray_done_idle_err", protocol_err, 1);
    chk("stray_done_idle_state", frame_ready, 1);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("accept_clears_err", protocol_err, 0);
    chk("accept_iter_start", iter_start, 1);
    tick();
    iter_done = 1'b1;
    tick();
    iter_done = 1'b0;
    chk("judge_entered", judge, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_frame_ready", frame_ready, 1);
    chk("midrst_judge", judge, 0);
    chk("midrst_frames_ok", frames_ok, 0);
    chk("midrst_frames_fail", frames_fail, 0);
    repeat (4) tick();
    chk("midrst_no_result", out_valid, 0);

    clear_plan(); flags[1] = 1'b1;                 run_frame(1'b0);  // pass on first
    clear_plan(); flags[3] = 1'b1;                 run_frame(1'b0);  // pass on third
    clear_plan();                                  run_frame(1'b0);  // iteration limit
    clear_plan(); tmo_at = 1;                      run_frame(1'b0);  // judge timeout
    clear_plan(); tmo_at = 4; flags[6] = 1'b1;     run_frame(1'b0);
    clear_plan(); flags[2] = 1'b1; hold_ready = 1'b1; run_frame(1'b1);  // backpressure

    for (int f = 0; f < 30; f++) begin
      clear_plan();
      for (int k = 1; k <= MAX_ITER; k++) flags[k] = ($urandom_range(0, 5) == 0);
      tmo_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, MAX_ITER)) : 0;
      repeat ($urandom_range(0, 3)) tick();
      run_frame(1'b0);
    end

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
